// File: rtl/restoring_div_hs.sv
// restoring_div_hs: sequential restoring divider, one quotient bit per clock,
// with valid/ready handshakes on both the operand and the result side.
// Optional macro DIV_SIGNED_EN adds two's-complement operation selected by sgn.
// Without the macro, sgn is ignored and no negation logic is built.
module restoring_div_hs #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIN, DONE} state_t;

  state_t        state_reg;
  logic [W:0]    a_reg;     // partial remainder, top bit is the sign of the trial
  logic [W-1:0]  q_reg;     // dividend shifting out, quotient shifting in
  logic [W-1:0]  m_reg;     // divisor magnitude
  logic [W-1:0]  d_reg;     // dividend as received, returned on divide-by-zero
  logic [CW-1:0] cnt_reg;
  logic          zero_reg;  // divisor was zero at acceptance

  logic [W:0]    a_shift;
  logic [W:0]    a_trial;
  logic [W-1:0]  dvd_mag;
  logic [W-1:0]  dvs_mag;

`ifdef DIV_SIGNED_EN
  logic          qneg_reg;  // quotient must be negated in FIN
  logic          rneg_reg;  // remainder must be negated in FIN
  logic [W:0]    dvd_ext;
  logic [W:0]    dvs_ext;
  logic          unused_ext;

  // Operand magnitudes, computed in W+1 bits so the most-negative value maps to 2^(W-1)
  always_comb begin
    dvd_ext = {dividend[W-1], dividend};
    dvs_ext = {divisor[W-1], divisor};
    if (sgn && dividend[W-1]) dvd_ext = -{dividend[W-1], dividend};
    if (sgn && divisor[W-1])  dvs_ext = -{divisor[W-1], divisor};
    dvd_mag = sgn ? dvd_ext[W-1:0] : dividend;
    dvs_mag = sgn ? dvs_ext[W-1:0] : divisor;
  end

  assign unused_ext = dvd_ext[W] ^ dvs_ext[W];
`else
  logic unused_sgn;

  // Unsigned build: operands are already magnitudes
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
  end

  assign unused_sgn = sgn;
`endif

  // One restoring step: shift {A,Q} left and trial-subtract the divisor
  always_comb begin
    a_shift = {a_reg[W-1:0], q_reg[W-1]};
    a_trial = a_shift - {1'b0, m_reg};
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      cnt_reg   <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      d_reg     <= '0;
      zero_reg  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= '0;
            q_reg     <= dvd_mag;
            m_reg     <= dvs_mag;
            d_reg     <= dividend;
            cnt_reg   <= '0;
            zero_reg  <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            qneg_reg  <= sgn & (dividend[W-1] ^ divisor[W-1]);
            rneg_reg  <= sgn & dividend[W-1];
`endif
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= (divisor == '0) ? FIN : ITER;
          end
        end
        ITER: begin
          a_reg   <= a_trial[W] ? a_shift : a_trial;
          q_reg   <= {q_reg[W-2:0], ~a_trial[W]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(W - 1)) state_reg <= FIN;
        end
        FIN: begin
          if (zero_reg) begin
            quotient  <= '1;
            remainder <= d_reg;
            dbz       <= 1'b1;
          end else begin
`ifdef DIV_SIGNED_EN
            quotient  <= qneg_reg ? -q_reg : q_reg;
            remainder <= rneg_reg ? -a_reg[W-1:0] : a_reg[W-1:0];
`else
            quotient  <= q_reg;
            remainder <= a_reg[W-1:0];
`endif
            dbz       <= 1'b0;
          end
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_hs.sv
// Self-checking bench for restoring_div_hs (W=8): table-driven divides plus
// hand-written back-pressure and mid-iteration reset sequences.
module tb_restoring_div_hs;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       sgn;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  restoring_div_hs #(.W(8)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dbz(dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operand pair, returns after the acceptance edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sgn      = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Counts edges after acceptance until out_valid rises (bounded)
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input vec_t v, input int lat);
    $display("div %02h/%02h sgn=%0b -> q=%02h r=%02h dbz=%0b lat=%0d", v.dvd, v.dvs, v.s,
             quotient, remainder, dbz, lat);
    chk("latency", lat, v.lat);
    chk("quotient", {24'd0, quotient}, {24'd0, v.q});
    chk("remainder", {24'd0, remainder}, {24'd0, v.r});
    chk("dbz", {31'd0, dbz}, {31'd0, v.z});
    chk("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   lat;

    // dividend, divisor, sgn, exp quotient, exp remainder, exp dbz, exp latency
    tbl.push_back('{8'd123, 8'd15,  1'b0, 8'd8,   8'd3,   1'b0, 9});
    tbl.push_back('{8'd200, 8'd0,   1'b0, 8'hFF,  8'd200, 1'b1, 1});
    tbl.push_back('{8'd7,   8'd9,   1'b0, 8'd0,   8'd7,   1'b0, 9});
    tbl.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 9});
    tbl.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 9});
    tbl.push_back('{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0, 9});
    tbl.push_back('{8'h85,  8'd15,  1'b0, 8'd8,   8'd13,  1'b0, 9});
    tbl.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 9});
`ifdef DIV_SIGNED_EN
    tbl.push_back('{8'h85,  8'd15,  1'b1, 8'hF8,  8'hFD,  1'b0, 9});
    tbl.push_back('{8'd123, 8'hF1,  1'b1, 8'hF8,  8'd3,   1'b0, 9});
    tbl.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'd0,   1'b0, 9});
    tbl.push_back('{8'h85,  8'd0,   1'b1, 8'hFF,  8'h85,  1'b1, 1});
`else
    tbl.push_back('{8'h85,  8'd15,  1'b1, 8'd8,   8'd13,  1'b0, 9});
    tbl.push_back('{8'h80,  8'hFF,  1'b1, 8'd0,   8'h80,  1'b0, 9});
`endif

    clr_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; sgn = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);

    // Back-to-back table with the consumer always ready
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      start_op(v.dvd, v.dvs, v.s);
      wait_result(lat);
      check_result(v, lat);
      @(posedge clk); #1;
      chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("in_ready_return", {31'd0, in_ready}, 32'd1);
    end

    // Back-pressure: hold the result for 20 cycles while a new request is offered
    out_ready = 1'b0;
    v = '{8'd123, 8'd15, 1'b0, 8'd8, 8'd3, 1'b0, 9};
    start_op(v.dvd, v.dvs, v.s);
    wait_result(lat);
    check_result(v, lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd7;
      @(posedge clk); #1;
      $display("hold cycle %0d: out_valid=%0b q=%02h r=%02h in_ready=%0b", i, out_valid,
               quotient, remainder, in_ready);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_quotient", {24'd0, quotient}, 32'd8);
      chk("hold_remainder", {24'd0, remainder}, 32'd3);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);

    // Reset during the fourth iteration cycle of 123/15
    start_op(8'd123, 8'd15, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_iter_busy", {31'd0, busy}, 32'd1);
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    $display("reset mid-iteration: in_ready=%0b out_valid=%0b q=%02h r=%02h", in_ready,
             out_valid, quotient, remainder);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_quotient", {24'd0, quotient}, 32'd0);
    chk("mid_rst_remainder", {24'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_idle_out_valid", {31'd0, out_valid}, 32'd0);
    v = '{8'd50, 8'd7, 1'b0, 8'd7, 8'd1, 1'b0, 9};
    start_op(v.dvd, v.dvs, v.s);
    wait_result(lat);
    check_result(v, lat);
    @(posedge clk); #1;
    chk("final_out_valid_drop", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
